// File: rtl/axi_master_write_burst.sv
// rtl/axi_master_write_burst.sv - AXI write-channel burst master with write-data FIFO
//
// Accepts one burst command at a time (address, beats-1, ID), drains write
// beats from an internal show-ahead FIFO onto the W channel and returns the
// B response to the requester as a one-cycle pulse.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   cmd_*                    burst command (valid/ready, addr, len = beats-1, id)
//   wd_*                     write beat push into the FIFO (ready = not full)
//   busy                     burst in flight
//   resp_valid, resp_code    registered completion pulse and response code
//   AW*_M, W*_M, B*_M        AXI master write channels
module axi_master_write_burst #(
  parameter int ID_BITS    = 4,
  parameter int ADDR_BITS  = 32,
  parameter int DATA_BITS  = 32,
  parameter int LEN_BITS   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int STRB_BITS  = DATA_BITS / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [LEN_BITS-1:0]  cmd_len,
  input  logic [ID_BITS-1:0]   cmd_id,
  input  logic                 wd_valid,
  output logic                 wd_ready,
  input  logic [DATA_BITS-1:0] wd_data,
  input  logic [STRB_BITS-1:0] wd_strb,
  output logic                 busy,
  output logic                 resp_valid,
  output logic [1:0]           resp_code,
  output logic [ID_BITS-1:0]   AWID_M,
  output logic [ADDR_BITS-1:0] AWADDR_M,
  output logic [LEN_BITS-1:0]  AWLEN_M,
  output logic [2:0]           AWSIZE_M,
  output logic [1:0]           AWBURST_M,
  output logic                 AWVALID_M,
  input  logic                 AWREADY_M,
  output logic [DATA_BITS-1:0] WDATA_M,
  output logic [STRB_BITS-1:0] WSTRB_M,
  output logic                 WLAST_M,
  output logic                 WVALID_M,
  input  logic                 WREADY_M,
  input  logic [ID_BITS-1:0]   BID_M,
  input  logic [1:0]           BRESP_M,
  input  logic                 BVALID_M,
  output logic                 BREADY_M
);

  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;
  localparam int ENT_BITS = DATA_BITS + STRB_BITS;
  localparam logic [2:0] AX_SIZE = 3'($clog2(STRB_BITS));

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [LEN_BITS-1:0]   len_q, len_d;
  logic [ID_BITS-1:0]    id_q, id_d;
  logic [LEN_BITS-1:0]   beats_q, beats_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [1:0]            resp_code_q, resp_code_d;

  logic [ENT_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_BITS-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_BITS-1:0]   count_q, count_d;
  logic                  fifo_full, fifo_empty, push, pop;
  logic [ENT_BITS-1:0]   head;

  // FIFO runs independently of the FSM so beats can be pre-filled in IDLE.
  assign fifo_full  = (count_q == CNT_BITS'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign wd_ready   = ~fifo_full;
  assign push       = wd_valid & ~fifo_full;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_BITS'(1);
    else if (pop && !push) count_d = count_q - CNT_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_BITS'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {wd_strb, wd_data};
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    id_d         = id_q;
    beats_d      = beats_q;
    resp_valid_d = 1'b0;
    resp_code_d  = resp_code_q;
    cmd_ready    = 1'b0;
    AWVALID_M    = 1'b0;
    AWID_M       = '0;
    AWADDR_M     = '0;
    AWLEN_M      = '0;
    WVALID_M     = 1'b0;
    WLAST_M      = 1'b0;
    BREADY_M     = 1'b0;
    pop          = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          id_d    = cmd_id;
          beats_d = cmd_len;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        AWVALID_M = 1'b1;
        AWID_M    = id_q;
        AWADDR_M  = addr_q;
        AWLEN_M   = len_q;
        if (AWREADY_M) state_d = S_DATA;
      end
      S_DATA: begin
        // An empty FIFO simply stalls the burst; the beat counter holds.
        WVALID_M = ~fifo_empty;
        WLAST_M  = ~fifo_empty & (beats_q == '0);
        pop      = ~fifo_empty & WREADY_M;
        if (pop) begin
          if (beats_q == '0) state_d = S_RESP;
          else               beats_d = beats_q - LEN_BITS'(1);
        end
      end
      S_RESP: begin
        BREADY_M = 1'b1;
        if (BVALID_M) begin
          resp_valid_d = 1'b1;
          // A response for a different ID is reported as SLVERR.
          resp_code_d  = (BID_M == id_q) ? BRESP_M : 2'b10;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      id_q         <= '0;
      beats_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_code_q  <= 2'b00;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      id_q         <= id_d;
      beats_q      <= beats_d;
      resp_valid_q <= resp_valid_d;
      resp_code_q  <= resp_code_d;
    end
  end

  // Data lines are forced to zero whenever no beat is offered.
  assign WDATA_M    = WVALID_M ? head[DATA_BITS-1:0] : '0;
  assign WSTRB_M    = WVALID_M ? head[ENT_BITS-1:DATA_BITS] : '0;
  assign AWSIZE_M   = AX_SIZE;
  assign AWBURST_M  = 2'b01;
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_code  = resp_code_q;

endmodule

// File: tb/tb_axi_master_write_burst.sv
// tb/tb_axi_master_write_burst.sv - randomized self-checking bench for axi_master_write_burst
module tb_axi_master_write_burst;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [3:0]  cmd_len = '0, cmd_id = '0;
  logic        wd_valid = 1'b0, wd_ready;
  logic [31:0] wd_data = '0;
  logic [3:0]  wd_strb = '0;
  logic        busy, resp_valid;
  logic [1:0]  resp_code;
  logic [3:0]  AWID_M, AWLEN_M;
  logic [31:0] AWADDR_M;
  logic [2:0]  AWSIZE_M;
  logic [1:0]  AWBURST_M;
  logic        AWVALID_M, AWREADY_M = 1'b0;
  logic [31:0] WDATA_M;
  logic [3:0]  WSTRB_M;
  logic        WLAST_M, WVALID_M, WREADY_M = 1'b0;
  logic [3:0]  BID_M = '0;
  logic [1:0]  BRESP_M = '0;
  logic        BVALID_M = 1'b0, BREADY_M;

  always #5 clk = ~clk;

  axi_master_write_burst #(
    .ID_BITS(4), .ADDR_BITS(32), .DATA_BITS(32), .LEN_BITS(4), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .busy(busy), .resp_valid(resp_valid), .resp_code(resp_code),
    .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M), .AWSIZE_M(AWSIZE_M),
    .AWBURST_M(AWBURST_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
    .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M), .WVALID_M(WVALID_M),
    .WREADY_M(WREADY_M),
    .BID_M(BID_M), .BRESP_M(BRESP_M), .BVALID_M(BVALID_M), .BREADY_M(BREADY_M)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: transaction phase (0 idle, 1 address, 2 data, 3 response),
  // queue of beats not yet offered, and queue of beats held by the master.
  logic [35:0] push_src[$];
  logic [35:0] model_fifo[$];
  int          phase = 0, beats_left = 0;
  logic [31:0] cur_addr = '0;
  logic [3:0]  cur_len = '0, cur_id = '0;
  logic        cmd_pending = 0, spam = 0, resp_pending = 0, accepted = 0;
  logic [1:0]  last_code = 2'b00, b_resp = 2'b00;
  logic        b_id_ok = 1'b1;
  int          aw_wait = 0, aw_cnt = 0, b_wait = 0, b_cnt = 0, wr_mode = 0, push_pct = 100;
  int          stall = 0, full_seen = 0, stall_seen = 0;
  logic        toggle = 1'b0, rst_now = 1'b0, post_reset = 1'b0;

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) push_src.push_back({4'($urandom), 32'($urandom)});
  endtask

  task automatic cycle();
    bit cmd_hs, aw_hs, w_hs, b_hs, push_hs, exp_wv;
    @(negedge clk);
    if (rst_now) begin
      rst = 1'b0; cmd_valid = 1'b0; wd_valid = 1'b0;
      AWREADY_M = 1'b0; WREADY_M = 1'b0; BVALID_M = 1'b0;
      phase = 0; model_fifo.delete(); push_src.delete();
      resp_pending = 0; last_code = 2'b00; cmd_pending = 0; spam = 0;
      rst_now = 1'b0; post_reset = 1'b1;
      return;
    end
    rst = 1'b1;
    wd_valid = (push_src.size() > 0) && ($urandom_range(0, 99) < push_pct);
    {wd_strb, wd_data} = (push_src.size() > 0) ? push_src[0] : 36'd0;
    cmd_valid = cmd_pending || (spam && phase == 3);
    if (cmd_pending) begin
      cmd_addr = cur_addr; cmd_len = cur_len; cmd_id = cur_id;
    end else begin
      cmd_addr = $urandom; cmd_len = 4'($urandom); cmd_id = 4'($urandom);
    end
    AWREADY_M = (phase == 1) ? (aw_cnt >= aw_wait) : 1'($urandom_range(0, 1));
    toggle = ~toggle;
    case (wr_mode)
      0:       WREADY_M = 1'b1;
      1:       WREADY_M = toggle;
      default: WREADY_M = 1'($urandom_range(0, 1));
    endcase
    BVALID_M = (phase == 3) && (b_cnt >= b_wait);
    BRESP_M  = b_resp;
    BID_M    = b_id_ok ? cur_id : (cur_id ^ 4'h5);
    #1;

    check("busy", busy, phase != 0);
    check("cmd_ready", cmd_ready, phase == 0);
    check("wd_ready", wd_ready, model_fifo.size() < DEPTH);
    if (model_fifo.size() == DEPTH) full_seen++;
    check("awvalid", AWVALID_M, phase == 1);
    if (phase == 1) begin
      check("awaddr", AWADDR_M, cur_addr);
      check("awid", AWID_M, cur_id);
      check("awlen", AWLEN_M, cur_len);
      check("awsize", AWSIZE_M, 3'd2);
      check("awburst", AWBURST_M, 2'b01);
    end
    exp_wv = (phase == 2) && (model_fifo.size() > 0);
    check("wvalid", WVALID_M, exp_wv);
    if (exp_wv) begin
      check("wdata", WDATA_M, model_fifo[0][31:0]);
      check("wstrb", WSTRB_M, model_fifo[0][35:32]);
      check("wlast", WLAST_M, beats_left == 1);
    end
    check("bready", BREADY_M, phase == 3);
    check("resp_valid", resp_valid, resp_pending);
    check("resp_code", resp_code, last_code);
    if (post_reset) begin
      check("rst_awaddr", AWADDR_M, 0);
      check("rst_awid", AWID_M, 0);
      check("rst_awlen", AWLEN_M, 0);
      check("rst_wdata", WDATA_M, 0);
      check("rst_wstrb", WSTRB_M, 0);
      check("rst_wlast", WLAST_M, 0);
      check("rst_awsize", AWSIZE_M, 3'd2);
      check("rst_awburst", AWBURST_M, 2'b01);
      post_reset = 1'b0;
    end

    cmd_hs  = (phase == 0) && cmd_valid;
    aw_hs   = (phase == 1) && AWREADY_M;
    w_hs    = exp_wv && WREADY_M;
    b_hs    = (phase == 3) && BVALID_M;
    push_hs = wd_valid && (model_fifo.size() < DEPTH);

    resp_pending = b_hs;
    if (w_hs) void'(model_fifo.pop_front());
    if (push_hs) model_fifo.push_back(push_src.pop_front());
    if (phase == 1 && !aw_hs) aw_cnt++;
    if (phase == 3 && !b_hs) b_cnt++;

    if (cmd_hs) begin
      phase = 1; cmd_pending = 0; aw_cnt = 0; accepted = 1;
      beats_left = int'(cur_len) + 1;
    end else if (aw_hs) begin
      phase = 2;
    end else if (w_hs) begin
      beats_left--;
      if (beats_left == 0) begin
        phase = 3; b_cnt = 0;
      end
    end else if (b_hs) begin
      last_code = b_id_ok ? b_resp : 2'b10;
      phase = 0;
    end

    // Starved burst: after a few idle cycles supply a fresh beat.
    if (phase == 2 && model_fifo.size() == 0 && push_src.size() == 0) begin
      stall++;
      if (stall >= 6) begin
        stall_seen = 1; stall = 0; push_rand(1);
      end
    end else begin
      stall = 0;
    end
  endtask

  task automatic start_burst(input logic [31:0] addr, input int len, input int id,
                             input int ppct, input int aww, input int wrm, input int bw,
                             input logic [1:0] br, input logic bok, input logic sp);
    cur_addr = addr; cur_len = 4'(len); cur_id = 4'(id);
    push_pct = ppct; aw_wait = aww; wr_mode = wrm; b_wait = bw;
    b_resp = br; b_id_ok = bok; spam = sp;
    cmd_pending = 1; accepted = 0; stall = 0;
  endtask

  task automatic finish_burst(input string tag);
    bit done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      cycle();
      done = accepted && phase == 0 && !resp_pending;
    end
    if (!done) check({tag, "_timeout"}, 0, 1);
    spam = 0;
  endtask

  task automatic burst(input logic [31:0] addr, input int len, input int id,
                       input int ppct, input int aww, input int wrm, input int bw,
                       input logic [1:0] br, input logic bok, input logic sp, input string tag);
    start_burst(addr, len, id, ppct, aww, wrm, bw, br, bok, sp);
    finish_burst(tag);
  endtask

  initial begin
    rst_now = 1'b1;
    cycle();
    rst_now = 1'b1;
    cycle();
    cycle();

    // Single pre-filled beat.
    push_pct = 100; wr_mode = 0;
    push_src.push_back({4'hF, 32'hDEADBEEF});
    repeat (3) cycle();
    burst(32'h0001_0000, 0, 1, 100, 0, 0, 0, 2'b00, 1'b1, 1'b0, "single");
    check("single_code", resp_code, 2'b00);
    check("single_busy", busy, 0);

    // 16-beat burst through a 4-entry FIFO.
    full_seen = 0;
    for (int i = 0; i < 16; i++) push_src.push_back({4'hF, 32'(i)});
    burst(32'h0002_0000, 15, 2, 100, 3, 0, 0, 2'b00, 1'b1, 1'b0, "len16");
    check("len16_full_seen", full_seen > 0, 1);

    // Backpressure on AW and W.
    push_rand(4);
    burst(32'h0003_0040, 3, 3, 60, 5, 1, 2, 2'b00, 1'b1, 1'b0, "bp");

    // FIFO underflow: only 2 of 4 beats available up front.
    stall_seen = 0;
    push_rand(2);
    burst(32'h0004_0000, 3, 4, 100, 0, 0, 0, 2'b00, 1'b1, 1'b0, "underflow");
    check("underflow_stalled", stall_seen, 1);

    // Error responses and command during RESP.
    push_rand(1);
    burst(32'h0005_0000, 0, 5, 100, 0, 0, 1, 2'b10, 1'b1, 1'b0, "errA");
    check("errA_code", resp_code, 2'b10);
    push_rand(1);
    burst(32'h0006_0000, 0, 6, 100, 0, 0, 0, 2'b00, 1'b0, 1'b0, "errB");
    check("errB_code", resp_code, 2'b10);
    push_rand(2);
    burst(32'h0007_0000, 1, 7, 100, 0, 0, 4, 2'b01, 1'b1, 1'b1, "errC");
    check("errC_code", resp_code, 2'b01);

    // Reset in the middle of the data phase.
    push_rand(4);
    start_burst(32'h0008_0000, 3, 8, 100, 0, 0, 0, 2'b00, 1'b1, 1'b0);
    for (int c = 0; c < 200 && !(phase == 2 && beats_left == 2); c++) cycle();
    check("rst_mid_reached", (phase == 2) && (beats_left == 2), 1);
    rst_now = 1'b1;
    cycle();
    cycle();
    check("rst_fifo_empty", wd_ready, 1);
    push_rand(2);
    burst(32'h0009_0000, 1, 9, 100, 0, 0, 0, 2'b00, 1'b1, 1'b0, "after_rst");

    // Randomized bursts with surplus beats carried between bursts.
    for (int n = 0; n < 25; n++) begin
      int len;
      len = $urandom_range(0, 15);
      push_rand(len + 1 + $urandom_range(0, 2));
      burst($urandom, len, $urandom_range(0, 15), $urandom_range(30, 100),
            $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3),
            2'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_master_write_burst.md
# axi_master_write_burst

Parametrised AXI write-channel master that supersedes the single-beat CPU write master. It accepts one burst command at a time (address, beat count, AXI ID) and buffers write beats in an internal FIFO. It then drives AW, W (with WLAST) and B handshakes with same-cycle valid/ready semantics, and returns the write response to the requester. It sits between the CPU/cache store path and one master port of the AXI interconnect.

## Interface
- ID_BITS, 4: AXI ID width
- ADDR_BITS, 32: address width
- DATA_BITS, 32: data width; must be 32, 64 or 128; STRB_BITS = DATA_BITS/8
- LEN_BITS, 4: AWLEN width; max burst = 2^LEN_BITS beats
- FIFO_DEPTH, 4: write-data FIFO entries; power of two, >= 2
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- cmd_valid  in  1  burst command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_addr  in  ADDR_BITS  start address, passed to AWADDR unchanged
- cmd_len  in  LEN_BITS  beats minus one
- cmd_id  in  ID_BITS  AWID for this burst
- wd_valid  in  1  write beat push
- wd_ready  out  1  FIFO not full
- wd_data  in  DATA_BITS  beat data
- wd_strb  in  STRB_BITS  beat byte strobes
- busy  out  1  burst in flight (replaces cpu_write_pause)
- resp_valid  out  1  one-cycle pulse at burst completion
- resp_code  out  2  final response code
- AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M(3), AWBURST_M(2), AWVALID_M  out: AW channel
- AWREADY_M  in  1
- WDATA_M, WSTRB_M, WLAST_M, WVALID_M  out: W channel
- WREADY_M  in  1
- BID_M(ID_BITS), BRESP_M(2), BVALID_M  in: B channel
- BREADY_M  out  1

## Operation
- States: IDLE, ADDR, DATA, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch addr/len/id, load the beat counter with cmd_len, and go to ADDR.
- ADDR: AWVALID_M=1 with latched fields. AWLEN_M=len, AWSIZE_M=log2(STRB_BITS), AWBURST_M=2'b01 (INCR). On AWVALID_M & AWREADY_M, go to DATA. AW fields stay stable while waiting.
- DATA: WVALID_M = FIFO non-empty. WDATA_M/WSTRB_M = FIFO head (show-ahead). WLAST_M=1 when the beat counter is 0. Each W handshake pops the FIFO and decrements the counter. A handshake with WLAST_M=1 moves to RESP.
- RESP: BREADY_M=1. On BVALID_M, pulse resp_valid and return to IDLE.
  - resp_code = BRESP_M when BID_M equals the latched id.
  - Otherwise resp_code = 2'b10 (SLVERR).
- W is never issued before the AW handshake completes.
- FIFO is independent of the FSM:
  - Pushes are allowed in any state while wd_ready=1, so beats may be pre-filled in IDLE.
  - Beats are consumed strictly in push order. Surplus beats remain for the next burst.
- Simultaneous push and pop on a full FIFO: the push is refused because wd_ready is already 0. Simultaneous push and pop on a non-empty, non-full FIFO: count unchanged.
- Empty FIFO in DATA: WVALID_M=0, the counter holds, and the FSM stays in DATA.
- cmd_valid outside IDLE: cmd_ready=0 and the command is ignored.
- busy = (state != IDLE).

## Timing
- Reset (rst=0 at a clock edge):
  - state IDLE and FIFO empty.
  - All AXI outputs 0, except AWSIZE_M/AWBURST_M which hold their constant values.
  - cmd_ready=1, wd_ready=1, busy=0, resp_valid=0, resp_code=0.
- Reset mid-burst aborts the burst without a response and discards FIFO contents.
- Command accepted at edge N: AWVALID_M is high from cycle N+1.
- Handshakes complete in the cycle where valid and ready are both high. The next state/beat is visible the following cycle, with no registered-ready delay.
- Minimum burst latency, 1 beat, with slave always ready and FIFO pre-filled:
  - AW in cycle N+1, W in N+2, B accepted in N+3 at the earliest.
  - resp_valid rises in the cycle BVALID_M is sampled with BREADY_M=1, and is registered out the following cycle.
- Full-rate bursts: one W beat per cycle while the FIFO is non-empty and WREADY_M=1.
- Counter wraps are impossible: load happens only in IDLE and decrement only on a non-last beat.

## Test plan
- Single beat:
  - Stimulus: pre-push 0xDEADBEEF with strb 4'hF, then cmd addr=0x0001_0000, len=0, id=1; AWREADY/WREADY/BVALID respond immediately with BRESP=00, BID=1.
  - Required: one AW with AWLEN=0, AWSIZE=2, AWBURST=01; one W with WLAST=1 and data 0xDEADBEEF; resp_valid pulse with resp_code=00; busy back to 0.
- 16-beat burst with FIFO_DEPTH=4:
  - Stimulus: cmd len=15; data 0..15 pushed at one beat per cycle.
  - Required: 16 W beats in order; WLAST only on data 15; wd_ready deasserts while the FIFO is full.
- Backpressure:
  - Stimulus: AWREADY held low for 5 cycles; WREADY toggling on alternate cycles.
  - Required: AW fields stable throughout; no W before the AW handshake; each beat held until accepted.
- FIFO underflow stall:
  - Stimulus: cmd len=3 with only 2 beats pushed.
  - Required: WVALID drops after beat 2; FSM remains in DATA; pushing beats 3 and 4 later completes the burst with WLAST on beat 4.
- Error paths:
  - Stimulus A: BRESP=10 with matching BID. Required: resp_code=10.
  - Stimulus B: BRESP=00 with BID≠id. Required: resp_code=10.
  - Stimulus C: cmd_valid asserted during RESP. Required: not accepted.
- Reset mid-DATA after 2 of 4 beats:
  - Required: all outputs at reset values next cycle; FIFO empty; a new command then completes normally.
